// File: rtl/dmem_pkg.sv
// Shared types and widths for the line-granular data memory responder.
package dmem_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2,
    TURN = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_line_array.sv
// Single-port line store: synchronous write, registered read, no reset so it maps to block RAM.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LINES = 512,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_line_responder.sv
// Fixed-latency 256-bit line memory responder with one-cycle ack and turnaround.
// Optional protocol checker enabled by defining DMEM_PROTOCOL_CHECK_EN.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int MEM_LATENCY = 10,
  parameter int DEPTH_LINES = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic [LINE_W-1:0] data_o,
  output logic              ack_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              ack_reg;
  logic              rd_valid_reg;
  logic              sample;
  logic              rd_en;
  logic              wr_en;
  logic              wr_lat_reg;
  logic [IDX_W-1:0]  idx_lat_reg;
  logic [LINE_W-1:0] wdata_lat_reg;
  logic [LINE_W-1:0] rd_data;
  logic              unused_addr;

  assign unused_addr = ^{addr_i[OFFSET_W-1:0], addr_i[ADDR_W-1:OFFSET_W+IDX_W]};

  // Counter is loaded with LATENCY-1 and ACK is entered on the edge after it hits
  // zero, so the ack lands exactly MEM_LATENCY edges after the sample edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sample     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable_i) begin
          sample     = 1'b1;
          cnt_next   = 8'(MEM_LATENCY - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == 8'd0) begin
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      ACK:     state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read is prefetched on the BUSY->ACK edge; write commits on the ACK exit edge.
  assign rd_en = (state_reg == BUSY) && (cnt_reg == 8'd0) && !wr_lat_reg;
  assign wr_en = (state_reg == ACK) && wr_lat_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      ack_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= (state_next == ACK);
      if (rd_en) begin
        rd_valid_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sample) begin
      wr_lat_reg    <= write_i;
      idx_lat_reg   <= addr_i[OFFSET_W +: IDX_W];
      wdata_lat_reg <= data_i;
    end
  end

  dmem_line_array #(
    .DEPTH_LINES(DEPTH_LINES),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk_i),
    .we   (wr_en),
    .re   (rd_en),
    .addr (idx_lat_reg),
    .wdata(wdata_lat_reg),
    .rdata(rd_data)
  );

  // The array output register has no reset, so data_o reads as zero until the first read.
  assign data_o = rd_valid_reg ? rd_data : '0;
  assign ack_o  = ack_reg;

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic [ADDR_W-OFFSET_W-1:0] tag_lat_reg;
  logic                       err_reg;

  always_ff @(posedge clk_i) begin
    if (sample) begin
      tag_lat_reg <= addr_i[ADDR_W-1:OFFSET_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_reg <= 1'b0;
    end else if (state_reg == BUSY &&
                 (!enable_i || write_i != wr_lat_reg ||
                  addr_i[ADDR_W-1:OFFSET_W] != tag_lat_reg)) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
// Scoreboard bench for dmem_line_responder: expectations queued at drive time, checked at each ack.
module tb_dmem_line_responder;

  localparam int LAT = 10;

  typedef struct {
    int         ack_cyc;
    logic [255:0] data;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic [255:0] data_o;
  logic         ack_o;
  logic         err_o;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  exp_t         sb[$];
  logic [255:0] model [512];
  logic [255:0] last_rd = '0;
  logic         exp_err;

  dmem_line_responder #(
    .MEM_LATENCY(LAT),
    .DEPTH_LINES(512)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .enable_i(enable_i),
    .write_i (write_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .ack_o   (ack_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Every ack must match the oldest queued expectation in cycle and data_o.
  always @(negedge clk_i) begin
    if (rst_i && ack_o) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 256'(ack_o), 256'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_cycle", 256'(cyc), 256'(e.ack_cyc));
        check("ack_data_o", data_o, e.data);
        $display("ack at cycle %0d data_o=%0h", cyc, data_o);
      end
    end
  end

  task automatic push_exp(input logic w, input logic [31:0] a, input logic [255:0] d, input int sample_cyc);
    exp_t e;
    if (w) begin
      model[a[13:5]] = d;
      e.data = last_rd;
    end else begin
      e.data  = model[a[13:5]];
      last_rd = e.data;
    end
    e.ack_cyc = sample_cyc + LAT;
    sb.push_back(e);
  endtask

  // Called just after a rising edge while the DUT is idle; sampled on the next edge.
  task automatic start_req(input logic w, input logic [31:0] a, input logic [255:0] d, input bit expect_ack);
    enable_i = 1'b1;
    write_i  = w;
    addr_i   = a;
    data_i   = d;
    if (expect_ack) push_exp(w, a, d, cyc + 1);
  endtask

  task automatic wait_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * LAT && !seen; i++) begin
      @(negedge clk_i);
      if (ack_o) seen = 1'b1;
    end
    if (!seen) check("ack_timeout", 256'(0), 256'(1));
  endtask

  // Initiator holds enable through the turnaround cycle, then drops it.
  task automatic finish_turn();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
  endtask

  task automatic run(input logic w, input logic [31:0] a, input logic [255:0] d);
    start_req(w, a, d, 1'b1);
    wait_ack();
    finish_turn();
  endtask

  task automatic pulse_reset();
    rst_i = 1'b0;
    #2;
    check("rst_ack_o", 256'(ack_o), 256'(0));
    check("rst_data_o", data_o, 256'(0));
    check("rst_err_o", 256'(err_o), 256'(0));
    last_rd  = '0;
    enable_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
  endtask

  initial begin
    logic [255:0] pa5, p1, p2, p3, p4, p5;
    pa5 = {32{8'hA5}};
    p1  = {8{32'h1234_5678}};
    p2  = {8{32'hDEAD_BEEF}};
    p3  = {8{32'h0BAD_F00D}};
    p4  = {8{32'h5555_AAAA}};
    p5  = {8{32'hC0FF_EE00}};
`ifdef DMEM_PROTOCOL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_i = 1'b0; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
    repeat (3) @(posedge clk_i); #1;
    check("reset_ack_o", 256'(ack_o), 256'(0));
    check("reset_data_o", data_o, 256'(0));
    check("reset_err_o", 256'(err_o), 256'(0));
    rst_i = 1'b1;

    // Write then read the same line.
    run(1'b1, 32'h0000_0400, pa5);
    run(1'b0, 32'h0000_0400, '0);

    // Idle with enable low: nothing moves.
    repeat (6) @(posedge clk_i); #1;
    check("idle_data_o", data_o, pa5);

    // Aliasing: 0x4020 maps onto the same line as 0x0020.
    run(1'b1, 32'h0000_0020, p1);
    run(1'b0, 32'h0000_4020, '0);

    // Back-to-back: write 0x1000 held through ack, then read 0x2000.
    run(1'b1, 32'h0000_2000, p2);
    start_req(1'b1, 32'h0000_1000, p3, 1'b1);
    wait_ack();
    write_i = 1'b0;
    addr_i  = 32'h0000_2000;
    push_exp(1'b0, 32'h0000_2000, '0, cyc + 3);
    wait_ack();
    finish_turn();
    repeat (3 * LAT) @(posedge clk_i); #1;
    check("post_turn_ack_o", 256'(ack_o), 256'(0));
    check("post_turn_data_o", data_o, p2);

    // Reset mid-write: no ack and the line keeps its earlier contents.
    run(1'b1, 32'h0000_0040, p4);
    start_req(1'b1, 32'h0000_0040, p5, 1'b0);
    repeat (5) @(posedge clk_i); #1;
    pulse_reset();
    repeat (2 * LAT) @(posedge clk_i); #1;
    run(1'b0, 32'h0000_0040, '0);

    // Address change during BUSY: checker flags it, transaction is unaffected.
    start_req(1'b0, 32'h0000_0400, '0, 1'b1);
    repeat (3) @(posedge clk_i); #1;
    addr_i = 32'h0000_0080;
    wait_ack();
    check("err_at_ack", 256'(err_o), 256'(exp_err));
    finish_turn();
    repeat (5) @(posedge clk_i); #1;
    check("err_sticky", 256'(err_o), 256'(exp_err));
    pulse_reset();
    check("err_after_reset", 256'(err_o), 256'(0));
    run(1'b0, 32'h0000_0020, '0);

    repeat (4) @(posedge clk_i); #1;
    check("scoreboard_empty", 256'(sb.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
